// File: rtl/ifmap_read_addr_gen_if.sv
// Bus between the IFMAP writer/control side and the read address generator.
// Carries the ovf flag only when IFRD_OVERFLOW_FLAG_EN is defined.
interface ifmap_read_addr_gen_if #(
  parameter int ADDR_W = 5,
  parameter int WIN_W  = 8
);
  logic              start;
  logic [WIN_W-1:0]  num_windows;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              win_last;
  logic              busy;
  logic              done;
  logic              spad_full;
  logic [ADDR_W:0]   occ;
`ifdef IFRD_OVERFLOW_FLAG_EN
  logic              ovf;

  modport master (
    output start, num_windows, wr_en,
    input  rd_en, rd_addr, win_last, busy, done, spad_full, occ, ovf
  );
  modport slave (
    input  start, num_windows, wr_en,
    output rd_en, rd_addr, win_last, busy, done, spad_full, occ, ovf
  );
`else
  modport master (
    output start, num_windows, wr_en,
    input  rd_en, rd_addr, win_last, busy, done, spad_full, occ
  );
  modport slave (
    input  start, num_windows, wr_en,
    output rd_en, rd_addr, win_last, busy, done, spad_full, occ
  );
`endif
endinterface

// File: rtl/ifmap_read_addr_gen.sv
// Sliding-window read address generator over the circular IFMAP scratchpad.
// Optional sticky overflow flag (port ovf) enabled by macro IFRD_OVERFLOW_FLAG_EN.
module ifmap_read_addr_gen #(
  parameter int SPAD_DEPTH = 11,
  parameter int ADDR_W     = 5,
  parameter int FILT_LEN   = 4,
  parameter int STRIDE     = 1,
  parameter int WIN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ifmap_read_addr_gen_if.slave  bus
);

  localparam int OCC_W = ADDR_W + 1;
  localparam logic [OCC_W-1:0]  DEPTH_O  = OCC_W'(SPAD_DEPTH);
  localparam logic [OCC_W-1:0]  FILT_O   = OCC_W'(FILT_LEN);
  localparam logic [OCC_W-1:0]  STRIDE_O = OCC_W'(STRIDE);
  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(FILT_LEN - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    READ      = 3'd2,
    ADVANCE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_k;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [WIN_W-1:0]  r_num_win;
  logic [OCC_W-1:0]  r_occ;
  logic              w_full;
  logic              w_inc;
  logic              w_last_win;
  logic [OCC_W-1:0]  w_rel;
  logic [OCC_W-1:0]  w_occ_nxt;

  // Operands are below SPAD_DEPTH (b at most SPAD_DEPTH), so one subtract wraps.
  function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                 input logic [OCC_W-1:0]  b);
    logic [OCC_W-1:0] s;
    s = {1'b0, a} + b;
    if (s >= DEPTH_O) s = s - DEPTH_O;
    return s[ADDR_W-1:0];
  endfunction

  function automatic logic [OCC_W-1:0] occ_update(input logic [OCC_W-1:0] occ,
                                                  input logic             inc,
                                                  input logic [OCC_W-1:0] rel);
    logic [OCC_W:0] s;
    s = {1'b0, occ} + {{OCC_W{1'b0}}, inc};
    if (s < {1'b0, rel}) s = '0;
    else                 s = s - {1'b0, rel};
    if (s > {1'b0, DEPTH_O}) s = {1'b0, DEPTH_O};
    return s[OCC_W-1:0];
  endfunction

  assign w_full     = (r_occ == DEPTH_O);
  assign w_inc      = bus.wr_en && !w_full;
  assign w_last_win = (r_win_cnt == r_num_win - 1'b1);
  // The last window releases its whole footprint so the next row begins at the writer.
  assign w_rel      = (r_state != ADVANCE) ? '0 : (w_last_win ? FILT_O : STRIDE_O);
  assign w_occ_nxt  = occ_update(r_occ, w_inc, w_rel);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (bus.start) w_state_nxt = (bus.num_windows == '0) ? DONE : WAIT_DATA;
      WAIT_DATA: if (r_occ >= FILT_O) w_state_nxt = READ;
      READ:      if (r_k == K_LAST) w_state_nxt = ADVANCE;
      ADVANCE:   w_state_nxt = w_last_win ? DONE : WAIT_DATA;
      DONE:      w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base    <= '0;
      r_k       <= '0;
      r_win_cnt <= '0;
      r_num_win <= '0;
      r_occ     <= '0;
    end else begin
      r_occ <= w_occ_nxt;
      case (r_state)
        IDLE:      if (bus.start) r_num_win <= bus.num_windows;
        WAIT_DATA: r_k <= '0;
        READ:      r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
        ADVANCE: begin
          r_base    <= mod_add(r_base, w_rel);
          r_win_cnt <= w_last_win ? '0 : r_win_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_en     = (r_state == READ);
  assign bus.rd_addr   = (r_state == READ) ? mod_add(r_base, {1'b0, r_k}) : '0;
  assign bus.win_last  = (r_state == READ) && (r_k == K_LAST);
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.spad_full = w_full;
  assign bus.occ       = r_occ;

`ifdef IFRD_OVERFLOW_FLAG_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else if ((bus.wr_en && w_full) || ({1'b0, w_rel} > ({1'b0, r_occ} + {{OCC_W{1'b0}}, w_inc})))
      r_ovf <= 1'b1;
  end
  assign bus.ovf = r_ovf;
`endif

endmodule
